// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipe_ctrl pipeline sequencer.
// Optional performance counters are enabled with PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_t;

    localparam int DEF_REG_AW = 5;

    localparam logic [5:0] RTYPE = 6'b101010;
    localparam logic [5:0] VLD   = 6'b100000;
    localparam logic [5:0] VSD   = 6'b100001;
    localparam logic [5:0] VBEZ  = 6'b100010;
    localparam logic [5:0] VBNEZ = 6'b100011;
    localparam logic [5:0] VNOP  = 6'b111100;

endpackage

// File: rtl/pipe_hazard_det.sv
// Register-match hazard detection between the ID instruction and the EX tracker.
// Purely combinational; the register file is write-first so WB is never checked.
module pipe_hazard_det
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              id_valid,
    input  logic              id_wrEn,
    input  logic              id_memEn,
    input  logic              id_memwrEn,
    input  logic              id_bez,
    input  logic              id_bnez,
    input  logic [REG_AW-1:0] id_rD,
    input  logic [REG_AW-1:0] id_rA,
    input  logic [REG_AW-1:0] id_rB,
    input  logic              ex_valid,
    input  logic              ex_wr,
    input  logic              ex_ld,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              hz
);

    logic is_ld;
    logic is_st;
    logic rd_src;
    logic ra_use;
    logic rb_use;
    logic match;

    assign is_ld  = id_memEn & ~id_memwrEn;
    assign is_st  = id_memEn & id_memwrEn;
    // stores and branches read rD rather than writing it
    assign rd_src = is_st | id_bez | id_bnez;
    assign ra_use = id_wrEn | is_ld;
    assign rb_use = id_wrEn;

    assign match = (rd_src & (id_rD == ex_rd))
                 | (ra_use & (id_rA == ex_rd))
                 | (rb_use & (id_rB == ex_rd));

    assign hz = id_valid & ex_valid & (ex_wr | ex_ld) & match;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/bubble/flush enables, dmem handshake with timeout.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = DEF_REG_AW,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic              id_wrEn,
    input  logic              id_memEn,
    input  logic              id_memwrEn,
    input  logic              id_bez,
    input  logic              id_bnez,
    input  logic [REG_AW-1:0] id_rD,
    input  logic [REG_AW-1:0] id_rA,
    input  logic [REG_AW-1:0] id_rB,
    input  logic              id_br_taken,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              pc_sel_br,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_bubble,
    output logic              exwb_en,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t            state;
    state_t            state_nx;
    logic [TW-1:0]     tmo;
    logic [TW-1:0]     tmo_nx;
    logic              err_q;
    logic              err_nx;
    logic              ex_valid;
    logic              ex_wr;
    logic              ex_ld;
    logic              ex_st;
    logic [REG_AW-1:0] ex_rd;
    logic              hz;
    logic              mem_pend;
    logic              br_take;
    logic              go;
    logic              load_ex;
    logic              bubble_ex;
    logic              stall_ev;
    logic              flush_ev;

    pipe_hazard_det #(.REG_AW(REG_AW)) u_hz (
        .id_valid   (id_valid),
        .id_wrEn    (id_wrEn),
        .id_memEn   (id_memEn),
        .id_memwrEn (id_memwrEn),
        .id_bez     (id_bez),
        .id_bnez    (id_bnez),
        .id_rD      (id_rD),
        .id_rA      (id_rA),
        .id_rB      (id_rB),
        .ex_valid   (ex_valid),
        .ex_wr      (ex_wr),
        .ex_ld      (ex_ld),
        .ex_rd      (ex_rd),
        .hz         (hz)
    );

    assign mem_pend = ex_valid & (ex_ld | ex_st);
    assign br_take  = (id_bez | id_bnez) & id_br_taken & id_valid;

    always_comb begin
        state_nx    = state;
        tmo_nx      = tmo;
        err_nx      = err_q;
        go          = 1'b0;
        load_ex     = 1'b0;
        bubble_ex   = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        pc_en       = 1'b0;
        pc_sel_br   = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_bubble = 1'b0;
        exwb_en     = 1'b0;
        dmem_req    = 1'b0;
        unique case (state)
            RUN: begin
                dmem_req = mem_pend;
                if (mem_pend && !dmem_ready) begin
                    state_nx = MEM_WAIT;
                    tmo_nx   = TW'(1);
                end else begin
                    go = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                tmo_nx   = tmo + 1'b1;
                if (dmem_ready) begin
                    go       = 1'b1;
                    state_nx = RUN;
                    tmo_nx   = '0;
                end else if (tmo == TW'(MEM_TIMEOUT - 1)) begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                end
            end
            default: ;
        endcase
        dmem_we = dmem_req & ex_st;
        if (go) begin
            priority case (1'b1)
                hz: begin
                    idex_en     = 1'b1;
                    idex_bubble = 1'b1;
                    exwb_en     = 1'b1;
                    bubble_ex   = 1'b1;
                    stall_ev    = 1'b1;
                end
                br_take: begin
                    pc_sel_br  = 1'b1;
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exwb_en    = 1'b1;
                    load_ex    = 1'b1;
                    flush_ev   = 1'b1;
                end
                default: begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    idex_en = 1'b1;
                    exwb_en = 1'b1;
                    load_ex = 1'b1;
                end
            endcase
        end
        // reset forces every output low regardless of the held state
        if (!reset_n) begin
            pc_en       = 1'b0;
            pc_sel_br   = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b0;
            idex_en     = 1'b0;
            idex_bubble = 1'b0;
            exwb_en     = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            stall_ev    = 1'b0;
            flush_ev    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= RUN;
            tmo      <= '0;
            err_q    <= 1'b0;
            ex_valid <= 1'b0;
            ex_wr    <= 1'b0;
            ex_ld    <= 1'b0;
            ex_st    <= 1'b0;
            ex_rd    <= '0;
        end else begin
            state <= state_nx;
            tmo   <= tmo_nx;
            err_q <= err_nx;
            if (bubble_ex) begin
                ex_valid <= 1'b0;
                ex_wr    <= 1'b0;
                ex_ld    <= 1'b0;
                ex_st    <= 1'b0;
            end else if (load_ex) begin
                ex_valid <= id_valid;
                ex_wr    <= id_wrEn;
                ex_ld    <= id_memEn & ~id_memwrEn;
                ex_st    <= id_memEn & id_memwrEn;
                ex_rd    <= id_rD;
            end
        end
    end

    assign mem_err = err_q & reset_n;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (flush_ev && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = reset_n ? stall_q : '0;
    assign flush_cnt = reset_n ? flush_q : '0;
`else
    logic unused_ev;
    assign unused_ev = stall_ev | flush_ev;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 4-stage vector core: IF, ID, EX/MEM, WB.
- Consumes per-instruction decode controls from the ID stage. Tracks the instruction in EX itself.
- Generates stall, bubble and flush enables for the PC and the IF/ID and ID/EX registers.
- Owns the data-memory request/ready handshake, including a timeout.

Parameters:
- REG_AW, 5, register address width.
- MEM_TIMEOUT, 64, maximum cycles to wait for dmem_ready before declaring an error.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction (not a NOP or bubble).
- id_wrEn  in  1  ID instruction writes rD from the ALU.
- id_memEn  in  1  ID instruction accesses data memory.
- id_memwrEn  in  1  ID access is a store.
- id_bez  in  1  ID instruction is VBEZ.
- id_bnez  in  1  ID instruction is VBNEZ.
- id_rD  in  REG_AW  destination register, or store/branch source register.
- id_rA  in  REG_AW  source A.
- id_rB  in  REG_AW  source B.
- id_br_taken  in  1  branch condition evaluated true in ID.
- dmem_ready  in  1  data memory completes the current access this cycle.
- pc_en  out  1  PC advances.
- pc_sel_br  out  1  PC loads the branch target.
- ifid_en  out  1  IF/ID register loads.
- ifid_flush  out  1  IF/ID register loads a NOP.
- idex_en  out  1  ID/EX register loads.
- idex_bubble  out  1  ID/EX register loads a NOP.
- exwb_en  out  1  EX/WB register loads.
- dmem_req  out  1  a memory access is pending in EX.
- dmem_we  out  1  the pending access is a store.
- mem_err  out  1  sticky timeout flag.
- stall_cnt  out  CNT_W  count of hazard-stall cycles.
- flush_cnt  out  CNT_W  count of branch flushes.

Behaviour:
- **Reset** (reset_n=0 at a rising edge):
  - FSM goes to RUN; EX tracker is invalid; timeout counter, mem_err and both counters are 0.
  - Outputs while reset is held: pc_en=ifid_en=idex_en=exwb_en=0, all other outputs 0.
  - Reset mid-wait abandons the access: dmem_req=0 the following cycle.
- **EX tracker** (registers): ex_valid, ex_wr, ex_ld, ex_st, ex_rd. A load is id_memEn&~id_memwrEn and counts as a writer of rD.
- **Hazard** (combinational): hz = id_valid & ex_valid & (ex_wr|ex_ld) & (id_rD_src|id_rA_use|id_rB_use match ex_rd).
  - rA and rB are used when id_wrEn is set, or on a load (rA only).
  - rD is a source for stores and branches.
  - The register file is write-first, so WB never hazards.
- **FSM states:** RUN, MEM_WAIT, ERR.
- **RUN:**
  - dmem_req = ex_valid & (ex_ld|ex_st); dmem_we = ex_st.
  - If dmem_req & ~dmem_ready: freeze (all enables 0). Next state MEM_WAIT; timeout counter=1.
  - Else if hz: pc_en=0, ifid_en=0, idex_en=1, idex_bubble=1, exwb_en=1. EX tracker loads a bubble.
  - Else if (id_bez|id_bnez) & id_br_taken & id_valid: pc_sel_br=1, pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, exwb_en=1.
  - Else: all enables 1. EX tracker loads the ID fields.
- **MEM_WAIT:**
  - dmem_req stays 1 with the same dmem_we; everything else is frozen.
  - On dmem_ready: that cycle behaves exactly as RUN without the memory stall, then return to RUN.
  - Timeout counter increments each waiting cycle. On reaching MEM_TIMEOUT without ready: set mem_err, go to ERR.
- **ERR:** all enables 0 and dmem_req=0 until reset.
- **Priority:** reset > memory freeze > hazard > branch. A branch whose source hazards stalls first and is flushed one cycle later.
- **Counters:** saturate at all-ones; no wrap-around.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: stall_cnt increments on each hazard-stall cycle. flush_cnt increments on each branch flush.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state encoding (RUN=2'b00, MEM_WAIT=2'b01, ERR=2'b10).
  - REG_AW default.
  - Opcode constants (RTYPE 6'b101010, VLD 6'b100000, VSD 6'b100001, VBEZ 6'b100010, VBNEZ 6'b100011, VNOP 6'b111100).
- One natural sub-module: pipe_hazard_det, the combinational register-match logic.

Test Plan:
1. **Load-use:** VLD r3 followed by RTYPE rA=3 -> exactly one cycle with idex_bubble=1, pc_en=0, ifid_en=0; stall_cnt=1.
2. **Taken branch:** VBNEZ with id_br_taken=1, no hazard -> one cycle with pc_sel_br=1, ifid_flush=1; flush_cnt=1.
3. **Memory wait:** VSD in EX with dmem_ready low for 3 cycles -> dmem_req=1 and dmem_we=1 for 4 cycles, all enables 0 for 3 cycles, advance on cycle 4.
4. **Timeout:** dmem_ready held 0 -> mem_err=1 after MEM_TIMEOUT cycles, then enables stay 0 and dmem_req=0 until reset.
5. **Priority:** hazard and taken branch in the same cycle -> stall first, flush on the next cycle. Memory stall during a hazard -> full freeze.
6. **Reset mid-wait:** assert reset_n=0 in MEM_WAIT -> next cycle state RUN, dmem_req=0, counters=0, mem_err=0.
